// File: rtl/pmem_arbiter.sv
// Arbiter for the single physical-memory port shared by the icache and dcache.
// Moore FSM with latched address/data, round-robin tie-break and a sticky watchdog.
module pmem_arbiter #(
  parameter int LINE_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t                  state;
  grant_t                  last_grant;
  logic [CNT_W-1:0]        wd_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the requester that did not win last time gets the port.
  assign grant_i = i_req && (!d_req || (last_grant == GRANT_D));

  function automatic state_t d_state(input logic wr);
    return wr ? D_WR : D_RD;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_i) begin
            state      <= I_RD;
            last_grant <= GRANT_I;
            addr_q     <= i_addr;
          end else if (d_req) begin
            state      <= d_state(d_write);
            last_grant <= GRANT_D;
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
          end
        end
        default: begin
          if (pmem_resp) begin
            state <= IDLE;
          end else if (wd_cnt == CNT_MAX) begin
            // Counter holds at its limit; the transaction keeps waiting for pmem.
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign pmem_read    = (state == I_RD) || (state == D_RD);
  assign pmem_write   = (state == D_WR);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = pmem_resp && (state == I_RD);
  assign d_resp  = pmem_resp && ((state == D_RD) || (state == D_WR));
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a scoreboard of expected grants is filled as
// requests are raised and drained as the memory side completes each transaction.
module tb_pmem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          err_timeout;

  pmem_arbiter #(
    .LINE_WIDTH    (LW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .err_timeout (err_timeout)
  );

  typedef struct {
    bit            is_i;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   err_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit is_i, input bit wr, input logic [AW-1:0] a,
                               input logic [LW-1:0] wd);
    exp_t e;
    e.is_i  = is_i;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    sb.push_back(e);
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    err_exp = 1'b0;
  endtask

  // Acts as pmem: waits for the grant, checks it against the scoreboard head,
  // responds in busy cycle lat, or pulses rst in busy cycle abort_at.
  task automatic serve(input int lat, input logic [LW-1:0] rd, input bit perturb,
                       input int abort_at);
    exp_t e;
    int   w;
    bit   got;
    w   = 0;
    got = 1'b0;
    while (!got && w < 16) begin
      tick();
      w++;
      if (pmem_read || pmem_write) got = 1'b1;
    end
    chk("grant_latency", LW'(w), LW'(1));
    if (!got) return;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected >0", sb.size());
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) tick();
      if (perturb && k == 2) begin
        d_addr  = 32'h0000_0200;
        d_wdata = ~d_wdata;
        i_addr  = i_addr ^ 32'h0000_0F00;
      end
      #1;
      if (k > TO) err_exp = 1'b1;
      chk("pmem_read", LW'(pmem_read), LW'(!e.wr));
      chk("pmem_write", LW'(pmem_write), LW'(e.wr));
      chk("pmem_address", LW'(pmem_address), LW'(e.addr));
      if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
      chk("err_timeout_busy", LW'(err_timeout), LW'(err_exp));
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        err_exp = 1'b0;
        chk("abort_pmem_read", LW'(pmem_read), LW'(0));
        chk("abort_pmem_write", LW'(pmem_write), LW'(0));
        chk("abort_d_resp", LW'(d_resp), LW'(0));
        chk("abort_i_resp", LW'(i_resp), LW'(0));
        chk("abort_err", LW'(err_timeout), LW'(0));
        return;
      end
      if (k == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        #1;
        chk("i_resp", LW'(i_resp), LW'(e.is_i));
        chk("d_resp", LW'(d_resp), LW'(!e.is_i));
        chk("i_rdata", i_rdata, rd);
        chk("d_rdata", d_rdata, rd);
      end else begin
        chk("i_resp_quiet", LW'(i_resp), LW'(0));
        chk("d_resp_quiet", LW'(d_resp), LW'(0));
      end
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("idle_pmem_read", LW'(pmem_read), LW'(0));
    chk("idle_pmem_write", LW'(pmem_write), LW'(0));
    chk("idle_err", LW'(err_timeout), LW'(err_exp));
  endtask

  initial begin
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    reset_dut();
    #1;
    chk("rst_pmem_read", LW'(pmem_read), LW'(0));
    chk("rst_pmem_write", LW'(pmem_write), LW'(0));
    chk("rst_i_resp", LW'(i_resp), LW'(0));
    chk("rst_d_resp", LW'(d_resp), LW'(0));
    chk("rst_err", LW'(err_timeout), LW'(0));
    chk("rst_address", LW'(pmem_address), LW'(0));
    chk("rst_wdata", pmem_wdata, LW'(0));

    // pmem_resp while idle must not produce a response
    pmem_resp  = 1'b1;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    #1;
    chk("idle_resp_i", LW'(i_resp), LW'(0));
    chk("idle_resp_d", LW'(d_resp), LW'(0));
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("idle_resp_state", LW'(pmem_read | pmem_write), LW'(0));

    // icache read, response in 5th busy cycle
    i_addr = 32'h0000_0060;
    i_read = 1'b1;
    push(1'b1, 1'b0, 32'h0000_0060, '0);
    serve(5, {32{8'hA5}}, 1'b0, 0);
    i_read = 1'b0;

    // dcache write-back with requester inputs changing mid-transaction
    d_addr  = 32'h0000_0100;
    d_wdata = {8{32'h1234_5678}};
    d_write = 1'b1;
    push(1'b0, 1'b1, 32'h0000_0100, {8{32'h1234_5678}});
    serve(4, {8{32'h0BAD_F00D}}, 1'b1, 0);
    d_write = 1'b0;

    // simultaneous d_read and d_write selects the write
    d_addr  = 32'h0000_0140;
    d_wdata = {8{32'hCAFE_0001}};
    d_read  = 1'b1;
    d_write = 1'b1;
    push(1'b0, 1'b1, 32'h0000_0140, {8{32'hCAFE_0001}});
    serve(2, {8{32'h5555_AAAA}}, 1'b0, 0);
    d_read  = 1'b0;
    d_write = 1'b0;

    // both caches held from reset: D, I, D, I
    reset_dut();
    i_addr = 32'h0000_0040;
    d_addr = 32'h0000_0080;
    i_read = 1'b1;
    d_read = 1'b1;
    push(1'b0, 1'b0, 32'h0000_0080, '0);
    push(1'b1, 1'b0, 32'h0000_0040, '0);
    push(1'b0, 1'b0, 32'h0000_0080, '0);
    push(1'b1, 1'b0, 32'h0000_0040, '0);
    for (int n = 0; n < 4; n++) serve(3, {8{32'h1000_0000 + n}}, 1'b0, 0);
    i_read = 1'b0;
    d_read = 1'b0;

    // watchdog: no response for longer than TIMEOUT_CYCLES, then a late response
    i_addr = 32'h0000_02C0;
    i_read = 1'b1;
    push(1'b1, 1'b0, 32'h0000_02C0, '0);
    serve(11, {8{32'h7777_0000}}, 1'b0, 0);
    i_read = 1'b0;
    tick();
    #1;
    chk("err_sticky", LW'(err_timeout), LW'(1));
    reset_dut();
    #1;
    chk("err_cleared", LW'(err_timeout), LW'(0));

    // reset in 2nd cycle of D_RD abandons it; a following icache read is served
    d_addr = 32'h0000_0300;
    d_read = 1'b1;
    push(1'b0, 1'b0, 32'h0000_0300, '0);
    serve(5, '0, 1'b0, 2);
    d_read = 1'b0;
    i_addr = 32'h0000_03C0;
    i_read = 1'b1;
    push(1'b1, 1'b0, 32'h0000_03C0, '0);
    serve(2, {8{32'h3C3C_3C3C}}, 1'b0, 0);
    i_read = 1'b0;

    chk("scoreboard_drained", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
